// File: rtl/pipe_scoreboard.sv
// pipe_scoreboard
// Hazard scoreboard for a pipelined MIPS-style core. It tracks every
// in-flight instruction from EX (stage 0) to WB (stage STAGES-1) and derives
// the load-use stall, bubble insertion, flush handling, EX operand
// forwarding selects and two saturating event counters.
//
// Ports
//   clk                      core clock, all state updates on the rising edge
//   rst_n                    asynchronous active-low reset, clears all state
//   hold                     global freeze: no state or counter changes while high
//   id_valid                 ID stage holds a real instruction
//   id_rs, id_rt             ID source register addresses
//   id_use_rs, id_use_rt     the ID instruction actually reads that source
//   id_dest, id_we           ID destination register and its write enable
//   id_load                  ID instruction is a load
//   flush                    branch/jump resolved in EX; the ID instruction is discarded
//   stall                    freeze PC and IF/ID, bubble ID/EX (combinational)
//   fwd_a_sel, fwd_b_sel     EX operand source: 0 = ID/EX value, k = result in stage k
//   stage_valid              per-stage valid bits
//   stall_count, flush_count saturating event counters
module pipe_scoreboard #(
  parameter int STAGES   = 3,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 2,
  localparam int SEL_W   = $clog2(STAGES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              hold,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_we,
  input  logic              id_load,
  input  logic              flush,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_a_sel,
  output logic [SEL_W-1:0]  fwd_b_sel,
  output logic [STAGES-1:0] stage_valid,
  output logic [15:0]       stall_count,
  output logic [15:0]       flush_count
);

  // Per-stage entry state
  logic [STAGES-1:0] valid_reg;
  logic [STAGES-1:0] we_reg;
  logic [STAGES-1:0] load_reg;
  logic [REG_AW-1:0] dest_reg [STAGES];

  // Source operands of the instruction currently in EX
  logic [REG_AW-1:0] src_a_reg;
  logic [REG_AW-1:0] src_b_reg;
  logic              use_a_reg;
  logic              use_b_reg;

  logic [15:0] stall_cnt_reg;
  logic [15:0] flush_cnt_reg;

  // Per-stage hazard terms
  logic [STAGES-1:0] id_hit;     // stage k writes a register the ID instruction reads
  logic [STAGES-1:0] load_hit;   // ... and it is a load whose data is not yet forwardable
  logic [STAGES-1:0] ex_hit_a;   // stage k writes EX operand A
  logic [STAGES-1:0] ex_hit_b;   // stage k writes EX operand B

  logic raw_stall;
  logic accept_next;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic writes;
      // r0 is hard-wired to zero, so a write to it never creates a dependency.
      assign writes = valid_reg[gi] && we_reg[gi] && (dest_reg[gi] != '0);

      assign id_hit[gi] = writes &&
                          ((id_use_rs && (dest_reg[gi] == id_rs)) ||
                           (id_use_rt && (dest_reg[gi] == id_rt)));

      // A load becomes forwardable once it reaches stage LOAD_LAT; the
      // consumer issues a cycle later, so only stages below LOAD_LAT-1 block.
      if (gi + 1 < LOAD_LAT) begin : g_load_block
        assign load_hit[gi] = id_hit[gi] && load_reg[gi];
      end else begin : g_load_free
        assign load_hit[gi] = 1'b0;
      end

      assign ex_hit_a[gi] = writes && use_a_reg && (dest_reg[gi] == src_a_reg);
      assign ex_hit_b[gi] = writes && use_b_reg && (dest_reg[gi] == src_b_reg);
    end
  endgenerate

  assign raw_stall = id_valid && (|load_hit);
  // A flushed ID instruction is discarded, so it has nothing to wait for.
  assign stall       = raw_stall && !flush;
  assign accept_next = id_valid && !stall && !flush;

  // Youngest writer wins: scan oldest to youngest so the lowest stage index
  // overrides. Stage 0 is the consumer itself and is never a source.
  always_comb begin
    fwd_a_sel = '0;
    fwd_b_sel = '0;
    for (int k = STAGES - 1; k >= 1; k--) begin
      if (ex_hit_a[k]) fwd_a_sel = SEL_W'(k);
      if (ex_hit_b[k]) fwd_b_sel = SEL_W'(k);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg     <= '0;
      we_reg        <= '0;
      load_reg      <= '0;
      for (int k = 0; k < STAGES; k++) dest_reg[k] <= '0;
      src_a_reg     <= '0;
      src_b_reg     <= '0;
      use_a_reg     <= 1'b0;
      use_b_reg     <= 1'b0;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else if (!hold) begin
      // Advance the pipeline; the WB entry falls off the end.
      valid_reg <= {valid_reg[STAGES-2:0], accept_next};
      we_reg    <= {we_reg[STAGES-2:0],    accept_next && id_we};
      load_reg  <= {load_reg[STAGES-2:0],  accept_next && id_load};
      for (int k = STAGES - 1; k >= 1; k--) dest_reg[k] <= dest_reg[k-1];
      dest_reg[0] <= id_dest;
      src_a_reg   <= id_rs;
      src_b_reg   <= id_rt;
      // Clearing the use bits on a bubble keeps its forwarding selects at 0.
      use_a_reg   <= accept_next && id_use_rs;
      use_b_reg   <= accept_next && id_use_rt;

      if (stall && (stall_cnt_reg != 16'hFFFF)) stall_cnt_reg <= stall_cnt_reg + 16'd1;
      if (flush && (flush_cnt_reg != 16'hFFFF)) flush_cnt_reg <= flush_cnt_reg + 16'd1;
    end
  end

  assign stage_valid = valid_reg;
  assign stall_count = stall_cnt_reg;
  assign flush_count = flush_cnt_reg;

endmodule

// File: tb/tb_pipe_scoreboard.sv
// Scoreboard bench for pipe_scoreboard. Two instances run side by side:
// dut 0 with default parameters and dut 1 with STAGES=5, LOAD_LAT=3.
// The driver pushes the expected outputs of every cycle into a per-DUT queue
// from a reference model that keeps a list of in-flight instructions; a
// separate monitor pops and compares on every falling clock edge.
module tb_pipe_scoreboard;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       hold [2];
  logic       id_valid [2];
  logic       id_use_rs [2];
  logic       id_use_rt [2];
  logic       id_we [2];
  logic       id_load [2];
  logic       flush [2];
  logic [4:0] id_rs [2];
  logic [4:0] id_rt [2];
  logic [4:0] id_dest [2];

  logic        stall_o [2];
  logic [15:0] sc [2];
  logic [15:0] fc [2];
  logic [2:0]  sv0;
  logic [1:0]  fa0, fb0;
  logic [4:0]  sv1;
  logic [2:0]  fa1, fb1;

  pipe_scoreboard u0 (
    .clk(clk), .rst_n(rst_n), .hold(hold[0]), .id_valid(id_valid[0]),
    .id_rs(id_rs[0]), .id_rt(id_rt[0]), .id_use_rs(id_use_rs[0]), .id_use_rt(id_use_rt[0]),
    .id_dest(id_dest[0]), .id_we(id_we[0]), .id_load(id_load[0]), .flush(flush[0]),
    .stall(stall_o[0]), .fwd_a_sel(fa0), .fwd_b_sel(fb0), .stage_valid(sv0),
    .stall_count(sc[0]), .flush_count(fc[0])
  );

  pipe_scoreboard #(.STAGES(5), .LOAD_LAT(3)) u1 (
    .clk(clk), .rst_n(rst_n), .hold(hold[1]), .id_valid(id_valid[1]),
    .id_rs(id_rs[1]), .id_rt(id_rt[1]), .id_use_rs(id_use_rs[1]), .id_use_rt(id_use_rt[1]),
    .id_dest(id_dest[1]), .id_we(id_we[1]), .id_load(id_load[1]), .flush(flush[1]),
    .stall(stall_o[1]), .fwd_a_sel(fa1), .fwd_b_sel(fb1), .stage_valid(sv1),
    .stall_count(sc[1]), .flush_count(fc[1])
  );

  // An in-flight instruction as the reference model sees it.
  typedef struct {
    bit v, we, ld, ua, ub;
    logic [4:0] d, rs, rt;
  } ent_t;

  typedef struct {
    int st, sv, fa, fb, sc, fc;
  } exp_t;

  ent_t m [2][5];     // m[u][k] = instruction k cycles past ID
  int   scnt [2];
  int   fcnt [2];
  bit   obs_stall [2];
  exp_t q0 [$];
  exp_t q1 [$];
  int   total = 0;
  int   bad = 0;

  function automatic int ns(int u); return (u == 0) ? 3 : 5; endfunction
  function automatic int ll(int u); return (u == 0) ? 2 : 3; endfunction

  function automatic bit hit(ent_t e, logic [4:0] s, bit use_s);
    return e.v && e.we && (e.d == s) && (s != 5'd0) && use_s;
  endfunction

  task automatic cmp(string n, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", n, act, exp, $time);
    end
  endtask

  task automatic set_in(int u, bit v, int rs, int rt, bit urs, bit urt,
                        int d, bit we, bit ld, bit fl, bit hd);
    id_valid[u]  = v;
    id_rs[u]     = 5'(rs);
    id_rt[u]     = 5'(rt);
    id_use_rs[u] = urs;
    id_use_rt[u] = urt;
    id_dest[u]   = 5'(d);
    id_we[u]     = we;
    id_load[u]   = ld;
    flush[u]     = fl;
    hold[u]      = hd;
  endtask

  task automatic idle(int u);
    set_in(u, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_in(int u, bit fl, bit hd);
    set_in(u, $urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 7),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, fl, hd);
  endtask

  // One clock cycle: predict this cycle's outputs, queue them, then advance
  // the model across the edge. Called at posedge+1, returns at posedge+1.
  task automatic step();
    exp_t e;
    bit   st, acc;
    #2;
    for (int u = 0; u < 2; u++) begin
      if (!rst_n) begin
        for (int k = 0; k < 5; k++) m[u][k] = '{default: 0};
        scnt[u] = 0;
        fcnt[u] = 0;
      end
      st = 1'b0;
      if (id_valid[u] && !flush[u])
        for (int k = 0; k < ns(u); k++)
          if (m[u][k].ld && (k + 1 < ll(u)) &&
              (hit(m[u][k], id_rs[u], id_use_rs[u]) || hit(m[u][k], id_rt[u], id_use_rt[u])))
            st = 1'b1;
      obs_stall[u] = stall_o[u];
      e.st = st;
      e.sv = 0;
      for (int k = 0; k < ns(u); k++) if (m[u][k].v) e.sv += (1 << k);
      e.fa = 0;
      e.fb = 0;
      for (int k = ns(u) - 1; k >= 1; k--) begin
        if (hit(m[u][k], m[u][0].rs, m[u][0].ua)) e.fa = k;
        if (hit(m[u][k], m[u][0].rt, m[u][0].ub)) e.fb = k;
      end
      e.sc = scnt[u];
      e.fc = fcnt[u];
      if (u == 0) q0.push_back(e); else q1.push_back(e);
      if (rst_n && !hold[u]) begin
        acc = id_valid[u] && !st && !flush[u];
        for (int k = ns(u) - 1; k >= 1; k--) m[u][k] = m[u][k-1];
        if (acc)
          m[u][0] = '{v: 1'b1, we: id_we[u], ld: id_load[u], ua: id_use_rs[u], ub: id_use_rt[u],
                      d: id_dest[u], rs: id_rs[u], rt: id_rt[u]};
        else
          m[u][0] = '{default: 0};
        if (st && scnt[u] < 65535) scnt[u]++;
        if (flush[u] && fcnt[u] < 65535) fcnt[u]++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Present an instruction in ID and keep it there while the DUT stalls.
  task automatic issue(int u, bit ld, bit we, int d, int rs, bit urs, int rt, bit urt,
                       output int nst);
    set_in(u, 1, rs, rt, urs, urt, d, we, ld, 0, 0);
    nst = 0;
    step();
    while (obs_stall[u]) begin
      nst++;
      if (nst > 8) begin
        cmp("stall_bound", nst, 8);
        break;
      end
      step();
    end
    $display("issue dut%0d ld=%0b we=%0b d=%0d rs=%0d/%0b rt=%0d/%0b stalls=%0d",
             u, ld, we, d, rs, urs, rt, urt, nst);
    idle(u);
  endtask

  // Monitor: one comparison set per queued cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        cmp("d0_stall", int'(stall_o[0]), e.st);
        cmp("d0_stage_valid", int'(sv0), e.sv);
        cmp("d0_fwd_a", int'(fa0), e.fa);
        cmp("d0_fwd_b", int'(fb0), e.fb);
        cmp("d0_stall_count", int'(sc[0]), e.sc);
        cmp("d0_flush_count", int'(fc[0]), e.fc);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        cmp("d1_stall", int'(stall_o[1]), e.st);
        cmp("d1_stage_valid", int'(sv1), e.sv);
        cmp("d1_fwd_a", int'(fa1), e.fa);
        cmp("d1_fwd_b", int'(fb1), e.fb);
        cmp("d1_stall_count", int'(sc[1]), e.sc);
        cmp("d1_flush_count", int'(fc[1]), e.fc);
      end
    end
  end

  initial begin
    int n, nsum;
    idle(0);
    idle(1);
    @(posedge clk);
    #1;

    // Reset held with random inputs
    rst_n = 1'b0;
    repeat (3) begin
      rand_in(0, $urandom_range(0, 1) == 1, 0);
      rand_in(1, $urandom_range(0, 1) == 1, 0);
      step();
    end
    cmp("rst_valid0", int'(sv0), 0);
    cmp("rst_valid1", int'(sv1), 0);
    cmp("rst_stall0", int'(stall_o[0]), 0);
    cmp("rst_fwd_a0", int'(fa0), 0);
    cmp("rst_fwd_b0", int'(fb0), 0);
    cmp("rst_counts0", int'(sc[0]) + int'(fc[0]), 0);
    rst_n = 1'b1;
    idle(0);
    idle(1);
    step();
    cmp("post_rst_valid0", int'(sv0), 0);
    cmp("post_rst_valid1", int'(sv1), 0);

    // ALU RAW: writer r3, consumer on rs, consumer on rt
    nsum = 0;
    issue(0, 0, 1, 3, 0, 0, 0, 0, n); nsum += n;
    issue(0, 0, 0, 0, 3, 1, 0, 0, n); nsum += n;
    cmp("alu_fwd_a", int'(fa0), 1);
    issue(0, 0, 0, 0, 0, 0, 3, 1, n); nsum += n;
    cmp("alu_fwd_b", int'(fb0), 2);
    cmp("alu_no_stall", nsum, 0);

    // Load-use: one stall cycle, then forward from WB
    issue(0, 1, 1, 5, 0, 0, 0, 0, n);
    issue(0, 0, 0, 0, 5, 1, 0, 0, n);
    cmp("lu_stall_cycles", n, 1);
    cmp("lu_fwd_a", int'(fa0), 2);
    cmp("lu_stall_count", int'(sc[0]), 1);

    // r0 never matches; youngest writer wins
    issue(0, 0, 1, 0, 0, 0, 0, 0, n);
    issue(0, 0, 0, 0, 0, 1, 0, 0, n);
    cmp("r0_fwd_a", int'(fa0), 0);
    cmp("r0_stall", n, 0);
    issue(0, 0, 1, 7, 0, 0, 0, 0, n);
    issue(0, 0, 1, 7, 0, 0, 0, 0, n);
    issue(0, 0, 0, 0, 7, 1, 0, 0, n);
    cmp("prio_fwd_a", int'(fa0), 1);

    // Flush in the same cycle as a load-use hazard
    issue(0, 1, 1, 5, 0, 0, 0, 0, n);
    set_in(0, 1, 5, 0, 1, 0, 0, 0, 0, 1, 0);
    step();
    cmp("flush_stall", int'(obs_stall[0]), 0);
    cmp("flush_bubble", int'(sv0[0]), 0);
    cmp("flush_count", int'(fc[0]), 1);
    cmp("flush_stall_count", int'(sc[0]), 1);
    idle(0);
    step();

    // Deeper pipeline, later load data
    issue(1, 1, 1, 5, 0, 0, 0, 0, n);
    issue(1, 0, 0, 0, 5, 1, 0, 0, n);
    cmp("deep_stall_cycles", n, 2);
    cmp("deep_fwd_a", int'(fa1), 3);
    cmp("deep_stall_count", int'(sc[1]), 2);

    // Reset in the middle of traffic
    issue(0, 0, 1, 4, 0, 0, 0, 0, n);
    rst_n = 1'b0;
    step();
    cmp("midrst_valid", int'(sv0), 0);
    cmp("midrst_counts", int'(sc[0]) + int'(fc[0]), 0);
    rst_n = 1'b1;
    step();
    cmp("midrst_idle_valid", int'(sv0), 0);

    // Hold freezes state and counters
    issue(0, 0, 1, 9, 0, 0, 0, 0, n);
    cmp("pre_hold_valid", int'(sv0), 1);
    repeat (4) begin
      rand_in(0, 1, 1);
      step();
    end
    cmp("hold_valid", int'(sv0), 1);
    cmp("hold_flush_count", int'(fc[0]), 0);
    cmp("hold_stall_count", int'(sc[0]), 0);
    idle(0);
    step();

    // Random traffic on both instances
    for (int i = 0; i < 400; i++) begin
      rand_in(0, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      rand_in(1, $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
      step();
    end
    idle(0);
    idle(1);

    // Drive the flush counter into saturation
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    repeat (65540) step();
    cmp("flush_sat", int'(fc[0]), 65535);
    idle(0);
    repeat (3) step();

    for (int i = 0; i < 10 && (q0.size() > 0 || q1.size() > 0); i++) @(negedge clk);
    #1;
    cmp("queues_drained", q0.size() + q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
